wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter NBits, default 32: datapath width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 stall  input  1  hold MEM/WB register contents.
REQ-005 flush  input  1  load a bubble into MEM/WB register.
REQ-006 in_Valid  input  1  MEM-stage slot holds a real instruction.
REQ-007 in_RegWrite  input  1  instruction writes the register file.
REQ-008 in_MemtoReg  input  1  write-back source is memory data.
REQ-009 in_ALUMemOrPC  input  1  jal-class: write PC+4 to r31.
REQ-010 in_WriteRegister  input  5  destination from decode (rt/rd).
REQ-011 in_ALUResult  input  NBits  ALU result.
REQ-012 in_ReadData  input  NBits  data-memory read data.
REQ-013 in_PCPlus4  input  NBits  return address.
REQ-014 out_RegWrite  output  1  register-file write enable.
REQ-015 out_WriteRegister  output  5  registered decode destination, unmodified.
REQ-016 out_ALUMemOrPC  output  1  registered jal flag; the decode stage forces r31 from it.
REQ-017 WriteData  output  NBits  selected write-back data.
REQ-018 fwd_Valid  output  1  forwarding entry valid.
REQ-019 fwd_Register  output  5  effective destination: 31 if jal, else out_WriteRegister.
REQ-020 fwd_Data  output  NBits  equals WriteData.
REQ-021 RetiredCount  output  32  count of instructions retired.

Function
REQ-022 The MEM/WB register SHALL capture all in_* fields on a rising edge when stall=0 and flush=0; latency is 1 cycle.
REQ-023 flush=1 SHALL load a bubble (valid=0, RegWrite=0, ALUMemOrPC=0, data fields 0) and SHALL win over stall.
REQ-024 stall=1, flush=0 SHALL hold every register field unchanged.
REQ-025 WriteData SHALL be in_PCPlus4 if ALUMemOrPC=1, else ReadData if MemtoReg=1, else ALUResult, all from registered fields; this is combinational.
REQ-026 out_RegWrite SHALL be valid AND RegWrite AND (fwd_Register != 0); writes to r0 are suppressed.
REQ-027 fwd_Valid SHALL equal out_RegWrite.
REQ-028 Outputs during a stall SHALL hold, and out_RegWrite SHALL stay asserted; a repeated write of the same value is permitted.
REQ-029 RetiredCount SHALL increment by 1 on each edge that loads in_Valid=1 with stall=0 and flush=0, regardless of RegWrite.
REQ-030 RetiredCount SHALL wrap from 0xFFFFFFFF to 0 with no flag.
REQ-031 A bubble or held slot SHALL NOT increment RetiredCount.

Reset
REQ-032 reset=0 SHALL immediately clear all register fields and RetiredCount to 0; all outputs then read 0.
REQ-033 Reset asserted mid-stall or mid-flush SHALL override both; the first capture after reset release follows REQ-022 to REQ-024.

Structure
REQ-034 The shared package SHALL hold NBits default 32, REG_ZERO=5'd0, REG_RA=5'd31 and the retired-counter width 32.
REQ-035 The MEM/WB register with stall/flush SHALL be one sub-module, wb_stage_reg; the muxing and counter live in wb_stage.

Verification
REQ-036 Scenario 1, R-type. ALUResult=0x1234, WriteRegister=8, RegWrite=1, Valid=1. Next cycle: WriteData=0x1234, out_RegWrite=1, fwd_Register=8, RetiredCount=1.
REQ-037 Scenario 2, load. MemtoReg=1, ReadData=0xDEADBEEF, ALUResult=0x40. Required: WriteData=0xDEADBEEF.
REQ-038 Scenario 3, jal. ALUMemOrPC=1, PCPlus4=0x00400008, WriteRegister=0. Required: WriteData=0x00400008, fwd_Register=31, out_WriteRegister=0, out_RegWrite=1.
REQ-039 Scenario 4, r0 write. WriteRegister=0, RegWrite=1. Required: out_RegWrite=0, fwd_Valid=0, RetiredCount still increments.
REQ-040 Scenario 5, stall then flush. Stall 3 cycles: outputs held and counter frozen. Then stall=1 with flush=1: bubble, out_RegWrite=0.
REQ-041 Scenario 6, wrap and reset. Preload the counter to 0xFFFFFFFF (retire 2^32-1 instructions or force it) and retire one more: RetiredCount=0. Assert reset=0 between clock edges: all outputs 0 immediately.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared constants, types and helpers for the write-back stage.
package wb_stage_pkg;

    localparam int         NBITS_DEFAULT = 32;
    localparam logic [4:0] REG_ZERO      = 5'd0;
    localparam logic [4:0] REG_RA        = 5'd31;
    localparam int         RETIRED_WIDTH = 32;

    typedef logic [4:0] regIdx_t;

    // Which datapath value feeds the register file.
    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_MEM = 2'd1,
        SRC_PC  = 2'd2
    } wbSrc_t;

    // A jal-class instruction always links into r31, whatever decode put in its destination field.
    function automatic regIdx_t effectiveDest(input logic isJal, input regIdx_t decodeDest);
        return isJal ? REG_RA : decodeDest;
    endfunction

    // The link address has priority over memory data, which has priority over the ALU result.
    function automatic wbSrc_t selectSource(input logic isJal, input logic memtoReg);
        if (isJal) begin
            return SRC_PC;
        end else if (memtoReg) begin
            return SRC_MEM;
        end
        return SRC_ALU;
    endfunction

endpackage

// File: rtl/wb_stage_reg.sv
// MEM/WB pipeline register with stall (hold) and flush (bubble) controls.
module wb_stage_reg
    import wb_stage_pkg::*;
#(
    parameter int NBits = NBITS_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             memValid,
    input  logic             memRegWrite,
    input  logic             memMemtoReg,
    input  logic             memJal,
    input  regIdx_t          memWriteRegister,
    input  logic [NBits-1:0] memAluResult,
    input  logic [NBits-1:0] memReadData,
    input  logic [NBits-1:0] memPcPlus4,
    output logic             wbValid,
    output logic             wbRegWrite,
    output logic             wbMemtoReg,
    output logic             wbJal,
    output regIdx_t          wbWriteRegister,
    output logic [NBits-1:0] wbAluResult,
    output logic [NBits-1:0] wbReadData,
    output logic [NBits-1:0] wbPcPlus4
);

    // Reset and flush both empty the slot; flush beats stall so a squashed slot never lingers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wbValid         <= 1'b0;
            wbRegWrite      <= 1'b0;
            wbMemtoReg      <= 1'b0;
            wbJal           <= 1'b0;
            wbWriteRegister <= REG_ZERO;
            wbAluResult     <= '0;
            wbReadData      <= '0;
            wbPcPlus4       <= '0;
        end else if (flush) begin
            wbValid         <= 1'b0;
            wbRegWrite      <= 1'b0;
            wbMemtoReg      <= 1'b0;
            wbJal           <= 1'b0;
            wbWriteRegister <= REG_ZERO;
            wbAluResult     <= '0;
            wbReadData      <= '0;
            wbPcPlus4       <= '0;
        end else if (!stall) begin
            wbValid         <= memValid;
            wbRegWrite      <= memRegWrite;
            wbMemtoReg      <= memMemtoReg;
            wbJal           <= memJal;
            wbWriteRegister <= memWriteRegister;
            wbAluResult     <= memAluResult;
            wbReadData      <= memReadData;
            wbPcPlus4       <= memPcPlus4;
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, write-back data select, forwarding info and retire counter.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int NBits = NBITS_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     in_Valid,
    input  logic                     in_RegWrite,
    input  logic                     in_MemtoReg,
    input  logic                     in_ALUMemOrPC,
    input  logic [4:0]               in_WriteRegister,
    input  logic [NBits-1:0]         in_ALUResult,
    input  logic [NBits-1:0]         in_ReadData,
    input  logic [NBits-1:0]         in_PCPlus4,
    output logic                     out_RegWrite,
    output logic [4:0]               out_WriteRegister,
    output logic                     out_ALUMemOrPC,
    output logic [NBits-1:0]         WriteData,
    output logic                     fwd_Valid,
    output logic [4:0]               fwd_Register,
    output logic [NBits-1:0]         fwd_Data,
    output logic [RETIRED_WIDTH-1:0] RetiredCount
);

    logic                     wbValid;
    logic                     wbRegWrite;
    logic                     wbMemtoReg;
    logic                     wbJal;
    regIdx_t                  wbWriteRegister;
    logic [NBits-1:0]         wbAluResult;
    logic [NBits-1:0]         wbReadData;
    logic [NBits-1:0]         wbPcPlus4;
    logic [NBits-1:0]         writeData;
    regIdx_t                  fwdRegister;
    logic                     regWriteEn;
    logic                     retireNow;
    logic [RETIRED_WIDTH-1:0] retiredCount;

    wb_stage_reg #(
        .NBits(NBits)
    ) u_reg (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .flush           (flush),
        .memValid        (in_Valid),
        .memRegWrite     (in_RegWrite),
        .memMemtoReg     (in_MemtoReg),
        .memJal          (in_ALUMemOrPC),
        .memWriteRegister(in_WriteRegister),
        .memAluResult    (in_ALUResult),
        .memReadData     (in_ReadData),
        .memPcPlus4      (in_PCPlus4),
        .wbValid         (wbValid),
        .wbRegWrite      (wbRegWrite),
        .wbMemtoReg      (wbMemtoReg),
        .wbJal           (wbJal),
        .wbWriteRegister (wbWriteRegister),
        .wbAluResult     (wbAluResult),
        .wbReadData      (wbReadData),
        .wbPcPlus4       (wbPcPlus4)
    );

    // Pick the write-back value from the registered slot; a bubble holds all zeros so this reads 0.
    always_comb begin
        writeData = wbAluResult;
        unique case (selectSource(wbJal, wbMemtoReg))
            SRC_PC:  writeData = wbPcPlus4;
            SRC_MEM: writeData = wbReadData;
            default: writeData = wbAluResult;
        endcase
    end

    assign fwdRegister = effectiveDest(wbJal, wbWriteRegister);
    assign regWriteEn  = wbValid & wbRegWrite & (fwdRegister != REG_ZERO);
    assign retireNow   = in_Valid & ~stall & ~flush;

    // Count every real instruction that enters the slot, whether or not it writes a register; wraps silently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retiredCount <= '0;
        end else if (retireNow) begin
            retiredCount <= retiredCount + {{(RETIRED_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign out_RegWrite      = regWriteEn;
    assign out_WriteRegister = wbWriteRegister;
    assign out_ALUMemOrPC    = wbJal;
    assign WriteData         = writeData;
    assign fwd_Valid         = regWriteEn;
    assign fwd_Register      = fwdRegister;
    assign fwd_Data          = writeData;
    assign RetiredCount      = retiredCount;

endmodule

// File: tb/tb_wb_stage.sv
// Directed scoreboard bench for the write-back stage.
module tb_wb_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        inValid;
    logic        inRegWrite;
    logic        inMemtoReg;
    logic        inJal;
    logic [4:0]  inWriteRegister;
    logic [31:0] inAluResult;
    logic [31:0] inReadData;
    logic [31:0] inPcPlus4;
    logic        outRegWrite;
    logic [4:0]  outWriteRegister;
    logic        outJal;
    logic [31:0] writeData;
    logic        fwdValid;
    logic [4:0]  fwdRegister;
    logic [31:0] fwdData;
    logic [31:0] retiredCount;

    typedef struct packed {
        logic [31:0] wd;
        logic        rw;
        logic [4:0]  wreg;
        logic        jal;
        logic        fv;
        logic [4:0]  freg;
        logic [31:0] cnt;
    } expected_t;

    expected_t scoreboard[$];

    int assertCount;
    int failCount;

    // Reference model state of the MEM/WB slot and counter.
    logic        mValid;
    logic        mRegWrite;
    logic        mMemtoReg;
    logic        mJal;
    logic [4:0]  mWriteRegister;
    logic [31:0] mAluResult;
    logic [31:0] mReadData;
    logic [31:0] mPcPlus4;
    logic [31:0] mCount;

    wb_stage #(
        .NBits(32)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .flush            (flush),
        .in_Valid         (inValid),
        .in_RegWrite      (inRegWrite),
        .in_MemtoReg      (inMemtoReg),
        .in_ALUMemOrPC    (inJal),
        .in_WriteRegister (inWriteRegister),
        .in_ALUResult     (inAluResult),
        .in_ReadData      (inReadData),
        .in_PCPlus4       (inPcPlus4),
        .out_RegWrite     (outRegWrite),
        .out_WriteRegister(outWriteRegister),
        .out_ALUMemOrPC   (outJal),
        .WriteData        (writeData),
        .fwd_Valid        (fwdValid),
        .fwd_Register     (fwdRegister),
        .fwd_Data         (fwdData),
        .RetiredCount     (retiredCount)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic compareField(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic zeroModel();
        mValid         = 1'b0;
        mRegWrite      = 1'b0;
        mMemtoReg      = 1'b0;
        mJal           = 1'b0;
        mWriteRegister = 5'd0;
        mAluResult     = 32'd0;
        mReadData      = 32'd0;
        mPcPlus4       = 32'd0;
    endtask

    task automatic pushExpected();
        expected_t e;
        e.wd   = mJal ? mPcPlus4 : (mMemtoReg ? mReadData : mAluResult);
        e.freg = mJal ? 5'd31 : mWriteRegister;
        e.rw   = mValid & mRegWrite & (e.freg != 5'd0);
        e.fv   = e.rw;
        e.wreg = mWriteRegister;
        e.jal  = mJal;
        e.cnt  = mCount;
        scoreboard.push_back(e);
    endtask

    task automatic checkOutput(input string tag);
        expected_t e;
        if (scoreboard.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL %s_scoreboard: observed=empty required=entry", tag);
            return;
        end
        e = scoreboard.pop_front();
        compareField({tag, "_WriteData"}, writeData, e.wd);
        compareField({tag, "_fwdData"}, fwdData, e.wd);
        compareField({tag, "_outRegWrite"}, {31'd0, outRegWrite}, {31'd0, e.rw});
        compareField({tag, "_fwdValid"}, {31'd0, fwdValid}, {31'd0, e.fv});
        compareField({tag, "_outWriteReg"}, {27'd0, outWriteRegister}, {27'd0, e.wreg});
        compareField({tag, "_outJal"}, {31'd0, outJal}, {31'd0, e.jal});
        compareField({tag, "_fwdReg"}, {27'd0, fwdRegister}, {27'd0, e.freg});
        compareField({tag, "_Retired"}, retiredCount, e.cnt);
    endtask

    // Drive one cycle at the falling edge, advance the model, check one unit after the rising edge.
    task automatic applyStimulus(
        input string       tag,
        input logic        sStall,
        input logic        sFlush,
        input logic        sValid,
        input logic        sRegWrite,
        input logic        sMemtoReg,
        input logic        sJal,
        input logic [4:0]  sWriteReg,
        input logic [31:0] sAlu,
        input logic [31:0] sRead,
        input logic [31:0] sPc
    );
        @(negedge clk);
        stall           = sStall;
        flush           = sFlush;
        inValid         = sValid;
        inRegWrite      = sRegWrite;
        inMemtoReg      = sMemtoReg;
        inJal           = sJal;
        inWriteRegister = sWriteReg;
        inAluResult     = sAlu;
        inReadData      = sRead;
        inPcPlus4       = sPc;
        if (sFlush) begin
            zeroModel();
        end else if (!sStall) begin
            mValid         = sValid;
            mRegWrite      = sRegWrite;
            mMemtoReg      = sMemtoReg;
            mJal           = sJal;
            mWriteRegister = sWriteReg;
            mAluResult     = sAlu;
            mReadData      = sRead;
            mPcPlus4       = sPc;
            if (sValid) begin
                mCount = mCount + 32'd1;
            end
        end
        pushExpected();
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic idleInputs();
        stall           = 1'b0;
        flush           = 1'b0;
        inValid         = 1'b0;
        inRegWrite      = 1'b0;
        inMemtoReg      = 1'b0;
        inJal           = 1'b0;
        inWriteRegister = 5'd0;
        inAluResult     = 32'd0;
        inReadData      = 32'd0;
        inPcPlus4       = 32'd0;
    endtask

    // Directed sequence of scenarios.
    initial begin
        assertCount = 0;
        failCount   = 0;
        mCount      = 32'd0;
        zeroModel();
        idleInputs();
        reset = 1'b0;

        #1;
        pushExpected();
        checkOutput("reset");

        @(negedge clk);
        reset = 1'b1;

        applyStimulus("rtype",  0, 0, 1, 1, 0, 0, 5'd8,  32'h0000_1234, 32'h0000_0000, 32'h0000_0000);
        applyStimulus("load",   0, 0, 1, 1, 1, 0, 5'd9,  32'h0000_0040, 32'hDEAD_BEEF, 32'h0000_0000);
        applyStimulus("jal",    0, 0, 1, 1, 0, 1, 5'd0,  32'h0000_0077, 32'h0000_0055, 32'h0040_0008);
        applyStimulus("r0wr",   0, 0, 1, 1, 0, 0, 5'd0,  32'h0000_0005, 32'h0000_0000, 32'h0000_0000);
        applyStimulus("store",  0, 0, 1, 0, 0, 0, 5'd3,  32'h0000_0100, 32'h0000_0000, 32'h0000_0000);
        applyStimulus("bubble", 0, 0, 0, 1, 0, 0, 5'd4,  32'h0000_0200, 32'h0000_0000, 32'h0000_0000);
        applyStimulus("pre",    0, 0, 1, 1, 0, 0, 5'd12, 32'h0000_ABCD, 32'h0000_0000, 32'h0000_0000);

        for (int i = 0; i < 3; i++) begin
            applyStimulus("stall", 1, 0, 1, 1, 1, 0, 5'd20 + 5'(i), 32'h1111_0000 + 32'(i),
                          32'h2222_0000, 32'h3333_0000);
        end
        applyStimulus("stflush", 1, 1, 1, 1, 0, 0, 5'd7,  32'h0000_9999, 32'h0000_0000, 32'h0000_0000);
        applyStimulus("flush",   0, 1, 1, 1, 0, 0, 5'd6,  32'h0000_8888, 32'h0000_0000, 32'h0000_0000);
        applyStimulus("after",   0, 0, 1, 1, 1, 0, 5'd5,  32'h0000_0001, 32'hCAFE_F00D, 32'h0000_0000);

        dut.retiredCount = 32'hFFFF_FFFF;
        mCount = 32'hFFFF_FFFF;
        #1;
        pushExpected();
        checkOutput("preload");
        applyStimulus("wrap", 0, 0, 1, 1, 0, 0, 5'd10, 32'h0000_0042, 32'h0000_0000, 32'h0000_0000);
        applyStimulus("post", 0, 0, 1, 1, 0, 0, 5'd11, 32'h0000_0043, 32'h0000_0000, 32'h0000_0000);

        @(negedge clk);
        stall   = 1'b1;
        flush   = 1'b1;
        inValid = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        zeroModel();
        mCount = 32'd0;
        pushExpected();
        checkOutput("asyncrst");
        @(posedge clk);
        #1;
        pushExpected();
        checkOutput("rsthold");

        @(negedge clk);
        idleInputs();
        reset = 1'b1;
        applyStimulus("restart", 0, 0, 1, 1, 0, 0, 5'd8, 32'h0000_1234, 32'h0000_0000, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
